// File: rtl/utopia_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// utopia_tx_arbiter_if
//   Bundles the requester-side and PHY-side signals of the Utopia transmit
//   arbiter.
//
//   Requester side : req (cell available per port), req_data (current byte per
//                    port, port i on [i*IfWidth +: IfWidth]), pop (advance
//                    port i), gnt (current cell owner, one-hot).
//   PHY side       : clav (cell space available), data (transmit byte),
//                    soc (start of cell), en (active-low transmit enable).
//
//   master : the arbiter (drives pop/gnt/data/soc/en).
//   slave  : the surrounding requesters and PHY.
// ---------------------------------------------------------------------------
interface utopia_tx_arbiter_if #(
    parameter int NumPorts = 4,
    parameter int IfWidth  = 8
) ();
    logic [NumPorts-1:0]         req;
    logic [NumPorts*IfWidth-1:0] req_data;
    logic [NumPorts-1:0]         pop;
    logic [NumPorts-1:0]         gnt;
    logic                        clav;
    logic [IfWidth-1:0]          data;
    logic                        soc;
    logic                        en;

    modport master (
        input  req, req_data, clav,
        output pop, gnt, data, soc, en
    );

    modport slave (
        output req, req_data, clav,
        input  pop, gnt, data, soc, en
    );
endinterface

// File: rtl/utopia_tx_arbiter.sv
// ---------------------------------------------------------------------------
// utopia_tx_arbiter
//   Round-robin arbiter that moves whole ATM cells from NumPorts requesters
//   onto a single Utopia transmit bus. A grant is only taken in IDLE (when
//   tx_enable and clav are both high); once granted, the cell always runs to
//   completion, followed by one GAP cycle and at least one IDLE cycle.
//
//   Ports
//     clk_in     : clock, everything on the rising edge
//     reset      : synchronous, active-low
//     tx_enable  : 1 = new grants allowed (a cell in flight always completes)
//     bus        : requester + PHY signals (master side, see interface)
//     cell_done  : one-cycle pulse after the last byte of a cell
//     cells_sent : count of completed cells, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module utopia_tx_arbiter #(
    parameter int NumPorts  = 4,
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                tx_enable,
    utopia_tx_arbiter_if.master bus,
    output logic                cell_done,
    output logic [15:0]         cells_sent
);
    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CntW  = $clog2(CellBytes);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state_q, state_d;
    logic [PortW-1:0]    last_grant_q;
    logic [PortW-1:0]    winner;
    logic [NumPorts-1:0] win_onehot;
    logic [CntW-1:0]     byte_cnt_q;
    logic                grant_now;
    logic                last_byte;

    // Round-robin search: start one past the previous owner and take the
    // first requesting port. last_grant also indexes the owner's data slice
    // for the whole cell, so no one-hot decode is needed on the data path.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every variable gets a default before any branch so the
        // block stays purely combinational (no latch).
        idx    = 0;
        found  = 1'b0;
        winner = last_grant_q;
        for (int k = 1; k <= NumPorts; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = PortW'(idx);
            end
        end
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    assign grant_now = (state_q == IDLE) && tx_enable && bus.clav && (bus.req != '0);
    assign last_byte = (byte_cnt_q == CntW'(CellBytes - 1));

    // State register
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: clav/tx_enable/req only matter in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_now) state_d = SEND;
            SEND:    if (last_byte) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational output: the owner is popped in every SEND cycle. Gated by
    // reset so a reset arriving mid-cell never advances a requester.
    always_comb begin
        bus.pop = '0;
        if (state_q == SEND && reset) bus.pop = bus.gnt;
    end

    // Registered outputs and datapath. The byte popped in a SEND cycle is
    // registered at the end of that cycle, so req_data never reaches an
    // output combinationally.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            bus.gnt      <= '0;
            bus.data     <= '0;
            bus.soc      <= 1'b0;
            bus.en       <= 1'b1;
            cell_done    <= 1'b0;
            cells_sent   <= '0;
            byte_cnt_q   <= '0;
            last_grant_q <= PortW'(NumPorts - 1);
        end else begin
            cell_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_now) begin
                        bus.gnt      <= win_onehot;
                        last_grant_q <= winner;
                        byte_cnt_q   <= '0;
                    end
                end
                SEND: begin
                    bus.data   <= bus.req_data[last_grant_q*IfWidth +: IfWidth];
                    bus.soc    <= (byte_cnt_q == '0);
                    bus.en     <= 1'b0;
                    byte_cnt_q <= byte_cnt_q + CntW'(1);
                end
                GAP: begin
                    bus.en     <= 1'b1;
                    bus.soc    <= 1'b0;
                    bus.gnt    <= '0;
                    cell_done  <= 1'b1;
                    cells_sent <= cells_sent + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_utopia_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_utopia_tx_arbiter
//   Directed bench for utopia_tx_arbiter. Requester p presents bytes
//   {p[1:0], index} where index walks 0..52 and advances on each pop, so a
//   cell from port p reads 0x00+p*0x40 .. 0x34+p*0x40.
// ---------------------------------------------------------------------------
module tb_utopia_tx_arbiter;
    localparam int NP = 4;
    localparam int W  = 8;
    localparam int CB = 53;

    logic        clk;
    logic        reset;
    logic        tx_enable;
    logic        cell_done;
    logic [15:0] cells_sent;

    utopia_tx_arbiter_if #(.NumPorts(NP), .IfWidth(W)) bus ();

    utopia_tx_arbiter #(.NumPorts(NP), .IfWidth(W), .CellBytes(CB)) dut (
        .clk_in     (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .bus        (bus),
        .cell_done  (cell_done),
        .cells_sent (cells_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model
    logic [5:0] ptr [NP];

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (!reset)          ptr[i] <= '0;
            else if (bus.pop[i]) ptr[i] <= (ptr[i] == 6'(CB - 1)) ? 6'd0 : ptr[i] + 6'd1;
        end
    end

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < NP; i++) bus.req_data[i*W +: W] = {2'(i), ptr[i]};
    end

    // Bus monitor, sampled on the falling edge
    int         pop_cycles, en_low, soc_cnt, soc_pos, done_cnt, overlap;
    int         min_gap, run_hi, cur_pops;
    bit         seen_low;
    logic [3:0] prev_gnt;
    logic [7:0] byte_q[$];
    int         grant_q[$];
    int         gpops_q[$];

    function automatic int oh2idx(input logic [NP-1:0] v);
        int r = -1;
        for (int i = 0; i < NP; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic clear_mon();
        pop_cycles = 0; en_low = 0; soc_cnt = 0; soc_pos = -1; done_cnt = 0;
        overlap = 0; min_gap = 1000; run_hi = 0; cur_pops = 0; seen_low = 0;
        prev_gnt = bus.gnt;
        byte_q.delete(); grant_q.delete(); gpops_q.delete();
    endtask

    always @(negedge clk) begin
        if (bus.pop != '0) pop_cycles++;
        if ($countones(bus.pop) > 1 || (bus.pop & ~bus.gnt) != '0) overlap++;
        if ($countones(bus.gnt) > 1) overlap++;
        if (!bus.en) begin
            if (bus.soc) begin
                soc_cnt++;
                if (soc_pos < 0) soc_pos = byte_q.size();
            end
            byte_q.push_back(bus.data);
            en_low++;
            if (seen_low && run_hi > 0 && run_hi < min_gap) min_gap = run_hi;
            run_hi   = 0;
            seen_low = 1'b1;
        end else begin
            if (bus.soc) soc_cnt++;
            run_hi++;
        end
        if (cell_done) done_cnt++;
        if (bus.gnt != '0 && prev_gnt == '0) begin
            grant_q.push_back(oh2idx(bus.gnt));
            cur_pops = 0;
        end
        if (bus.pop != '0) cur_pops++;
        if (bus.gnt == '0 && prev_gnt != '0) gpops_q.push_back(cur_pops);
        prev_gnt = bus.gnt;
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    // Advance until cell_done is seen, bounded.
    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!cell_done && n < budget);
        check("cell_done_seen", 32'(cell_done), 32'd1);
    endtask

    int exp_rr [5] = '{0, 1, 2, 3, 0};
    int bad;

    initial begin
        reset = 1'b0; tx_enable = 1'b0; bus.req = '0; bus.clav = 1'b0;
        clear_mon();
        repeat (3) step();

        // Reset state
        check("rst_gnt",   32'(bus.gnt),  32'h0);
        check("rst_pop",   32'(bus.pop),  32'h0);
        check("rst_en",    32'(bus.en),   32'h1);
        check("rst_soc",   32'(bus.soc),  32'h0);
        check("rst_data",  32'(bus.data), 32'h0);
        check("rst_done",  32'(cell_done), 32'h0);
        check("rst_count", 32'(cells_sent), 32'h0);

        // Single cell from port 0, granted on the first edge with reset high
        clear_mon();
        reset = 1'b1; bus.req = 4'b0001; bus.clav = 1'b1; tx_enable = 1'b1;
        step();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_pop", 32'(bus.pop), 32'h1);
        check("t1_en_first", 32'(bus.en), 32'h1);
        wait_done(80);
        bus.req = '0;
        step();
        check("t1_en_low",  32'(en_low), 32'd53);
        check("t1_nbytes",  32'(byte_q.size()), 32'd53);
        bad = 0;
        for (int k = 0; k < byte_q.size(); k++) if (byte_q[k] !== 8'(k)) bad++;
        check("t1_byte_order", 32'(bad), 32'd0);
        check("t1_soc_cnt", 32'(soc_cnt), 32'd1);
        check("t1_soc_pos", 32'(soc_pos), 32'd0);
        check("t1_pops",    32'(pop_cycles), 32'd53);
        check("t1_done",    32'(done_cnt), 32'd1);
        check("t1_count",   32'(cells_sent), 32'd1);
        check("t1_data_hold", 32'(bus.data), 32'h34);
        check("t1_idle_en", 32'(bus.en), 32'h1);

        // Round robin from reset with all ports requesting
        reset = 1'b0;
        repeat (2) step();
        clear_mon();
        reset = 1'b1; bus.req = 4'b1111;
        step();
        repeat (5) wait_done(80);
        bus.req = '0;
        step();
        check("rr_ngrants", 32'(grant_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < grant_q.size(); k++)
            check("rr_order", 32'(grant_q[k]), 32'(exp_rr[k]));
        bad = 0;
        foreach (gpops_q[k]) if (gpops_q[k] != CB) bad++;
        check("rr_npopruns", 32'(gpops_q.size()), 32'd5);
        check("rr_pops_per_grant", 32'(bad), 32'd0);
        check("rr_overlap", 32'(overlap), 32'd0);
        check("rr_min_gap", 32'(min_gap), 32'd2);
        check("rr_nbytes", 32'(byte_q.size()), 32'd265);
        if (byte_q.size() == 265) begin
            check("rr_p1_first", 32'(byte_q[53]),  32'h40);
            check("rr_p2_first", 32'(byte_q[106]), 32'h80);
            check("rr_p3_first", 32'(byte_q[159]), 32'hC0);
            check("rr_p0_last",  32'(byte_q[264]), 32'h34);
        end
        check("rr_count", 32'(cells_sent), 32'd5);

        // Backpressure: clav low blocks the grant, clav drop mid-cell ignored
        clear_mon();
        bus.clav = 1'b0; bus.req = 4'b0010;
        repeat (10) step();
        check("bp_no_pop",   32'(pop_cycles), 32'd0);
        check("bp_no_en",    32'(en_low), 32'd0);
        check("bp_no_gnt",   32'(bus.gnt), 32'h0);
        bus.clav = 1'b1;
        step();
        check("bp_gnt", 32'(bus.gnt), 32'h2);
        repeat (10) step();
        bus.clav = 1'b0;
        wait_done(80);
        bus.req = '0;
        repeat (3) step();
        check("bp_en_low",  32'(en_low), 32'd53);
        check("bp_pops",    32'(pop_cycles), 32'd53);
        check("bp_gnt_clr", 32'(bus.gnt), 32'h0);
        if (byte_q.size() == 53) begin
            check("bp_first",  32'(byte_q[0]),  32'h40);
            check("bp_byte10", 32'(byte_q[10]), 32'h4A);
            check("bp_last",   32'(byte_q[52]), 32'h74);
        end
        check("bp_count", 32'(cells_sent), 32'd6);

        // tx_enable dropped mid-cell: cell completes, then no new grant
        clear_mon();
        bus.clav = 1'b1; bus.req = 4'b1111;
        step();
        check("te_gnt", 32'(bus.gnt), 32'h4);
        repeat (20) step();
        tx_enable = 1'b0;
        wait_done(80);
        repeat (10) step();
        check("te_hold_gnt",  32'(bus.gnt), 32'h0);
        check("te_hold_en",   32'(bus.en), 32'h1);
        check("te_ngrants",   32'(grant_q.size()), 32'd1);
        check("te_en_low",    32'(en_low), 32'd53);
        tx_enable = 1'b1;
        step();
        check("te_next_gnt", 32'(bus.gnt), 32'h8);
        wait_done(80);
        bus.req = '0;
        step();
        check("te_count", 32'(cells_sent), 32'd8);

        // Reset mid-cell aborts without cell_done or count
        reset = 1'b0;
        repeat (2) step();
        clear_mon();
        reset = 1'b1; bus.req = 4'b0001;
        step();
        check("ra_gnt", 32'(bus.gnt), 32'h1);
        repeat (30) step();
        reset = 1'b0;
        #1;
        check("ra_pop_in_reset", 32'(bus.pop), 32'h0);
        step();
        check("ra_en",    32'(bus.en), 32'h1);
        check("ra_gnt0",  32'(bus.gnt), 32'h0);
        check("ra_soc",   32'(bus.soc), 32'h0);
        check("ra_count", 32'(cells_sent), 32'd0);
        step();
        check("ra_no_done", 32'(done_cnt), 32'd0);
        reset = 1'b1; bus.req = 4'b1000;
        step();
        check("ra_gnt3", 32'(bus.gnt), 32'h8);
        wait_done(80);
        bus.req = '0;
        step();
        check("ra_done1",   32'(done_cnt), 32'd1);
        check("ra_count1",  32'(cells_sent), 32'd1);
        check("ra_data_p3", 32'(bus.data), 32'hF4);

        // Counter wrap from 16'hFFFF
        force dut.cells_sent = 16'hFFFF;
        #1;
        release dut.cells_sent;
        clear_mon();
        bus.req = 4'b0100;
        step();
        check("wr_gnt", 32'(bus.gnt), 32'h4);
        wait_done(80);
        bus.req = '0;
        check("wr_count", 32'(cells_sent), 32'd0);
        step();
        check("wr_done",  32'(done_cnt), 32'd1);
        check("wr_data",  32'(bus.data), 32'hB4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
